// File: rtl/ws2812b_strip_arbiter_pkg.sv
// rtl/ws2812b_strip_arbiter_pkg.sv - shared constants and types for the ws2812b strip arbiter
//
// Purpose: pixel width, owner encoding and arbiter state type shared by the
// arbiter, its pixel-port interface and the ledstrip peripheral.
// Ports: none (package).
package ws2812b_strip_arbiter_pkg;

    localparam int WS2812B_PIXEL_W = 24;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ws2812b_strip_arbiter_if.sv
// rtl/ws2812b_strip_arbiter_if.sv - ws2812b pixel port (data/valid/latch/ready)
//
// Purpose: one pixel handshake link towards a ws2812b serializer.
// Signals:
//   data  [WS2812B_PIXEL_W] pixel, GRB order
//   valid                   pixel offered
//   latch                   this pixel ends the frame
//   ready                   pixel accepted this cycle when valid is high
// Modports: master drives data/valid/latch, slave drives ready.
interface ws2812b_strip_arbiter_if
    import ws2812b_strip_arbiter_pkg::*;
();

    logic [WS2812B_PIXEL_W-1:0] data;
    logic                       valid;
    logic                       latch;
    logic                       ready;

    modport master (output data, output valid, output latch, input  ready);
    modport slave  (input  data, input  valid, input  latch, output ready);

endinterface

// File: rtl/ws2812b_strip_arbiter.sv
// rtl/ws2812b_strip_arbiter.sv - frame-granular round-robin arbiter for one ws2812b serializer
//
// Purpose: shares one ws2812b serializer between requester A (CPU register
// path) and requester B. A grant lasts from the first pixel through the
// pixel carrying latch, so frames never interleave; ownership alternates
// round-robin on ties.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   a, b          requester pixel ports (slave side)
//   s             serializer pixel port (master side)
//   busy          a frame owner is currently granted
//   owner         current or last owner (0 = A, 1 = B)
//   frame_done    one-cycle pulse the cycle after a latch pixel transfers
//   timeout_flag  sticky, set by a forced release
//   timeout_clr   clears timeout_flag (set wins in the same cycle)
// Parameter: TIMEOUT_CYCLES (2..65535) stall limit before forced release.
// Build option: WS2812B_ARB_TIMEOUT_EN enables the stall counter and
// forced release; without it timeout_flag is 0 and timeout_clr is ignored.
module ws2812b_strip_arbiter
    import ws2812b_strip_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ws2812b_strip_arbiter_if.slave   a,
    ws2812b_strip_arbiter_if.slave   b,
    ws2812b_strip_arbiter_if.master  s,
    output logic                     busy,
    output logic                     owner,
    output logic                     frame_done,
    output logic                     timeout_flag,
    input  logic                     timeout_clr
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_OWN  = OWN;

    logic [0:0]                 state;
    logic                       rr_last;
    logic                       in_own;
    logic                       own_valid;
    logic                       own_latch;
    logic [WS2812B_PIXEL_W-1:0] own_data;
    logic                       xfer;
    logic                       xfer_last;
    logic                       timeout_evt;
    logic                       req_any;
    logic                       grant_pick;

    assign in_own    = (state == ST_OWN);
    assign own_valid = (owner == OWNER_B) ? b.valid : a.valid;
    assign own_latch = (owner == OWNER_B) ? b.latch : a.latch;
    assign own_data  = (owner == OWNER_B) ? b.data  : a.data;

    // Zero-latency pass-through; owner is the only registered element on the path.
    assign s.valid = in_own & own_valid;
    assign s.latch = in_own & own_latch;
    assign s.data  = in_own ? own_data : '0;
    assign a.ready = in_own & (owner == OWNER_A) & s.ready;
    assign b.ready = in_own & (owner == OWNER_B) & s.ready;

    assign xfer      = s.valid & s.ready;
    assign xfer_last = xfer & own_latch;
    assign busy      = in_own;

    // Lone requester wins outright; on a tie the one that did not own last wins.
    assign req_any    = a.valid | b.valid;
    assign grant_pick = (a.valid & b.valid) ? ~rr_last : ~a.valid;

`ifdef WS2812B_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] stall_cnt;

    // Release fires on the stalled cycle that brings the counter to the limit.
    assign timeout_evt = in_own & ~xfer & (stall_cnt >= TIMEOUT_LIM - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!in_own || xfer) begin
            stall_cnt <= '0;
        end else if (stall_cnt != TIMEOUT_LIM) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_flag <= 1'b0;
        end else if (timeout_evt) begin
            timeout_flag <= 1'b1;
        end else if (timeout_clr) begin
            timeout_flag <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_evt    = 1'b0;
    assign timeout_flag   = 1'b0;
    assign unused_timeout = timeout_clr | (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWNER_A;
            rr_last    <= OWNER_B;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer_last;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        state <= ST_OWN;
                        owner <= grant_pick;
                    end
                end
                default: begin
                    // A forced release sends no latch; the owner's next pixels
                    // simply continue the strip on a later grant.
                    if (xfer_last || timeout_evt) begin
                        state   <= ST_IDLE;
                        rr_last <= owner;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_strip_arbiter.sv
// tb/tb_ws2812b_strip_arbiter.sv - self-checking bench for ws2812b_strip_arbiter
module tb_ws2812b_strip_arbiter;
    import ws2812b_strip_arbiter_pkg::*;

    localparam int TO_CYC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, owner, frame_done, timeout_flag;
    logic timeout_clr = 1'b0;

    ws2812b_strip_arbiter_if a_if ();
    ws2812b_strip_arbiter_if b_if ();
    ws2812b_strip_arbiter_if s_if ();

    ws2812b_strip_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a_if),
        .b            (b_if),
        .s            (s_if),
        .busy         (busy),
        .owner        (owner),
        .frame_done   (frame_done),
        .timeout_flag (timeout_flag),
        .timeout_clr  (timeout_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester sources: queues of {latch, data}; valid held until accepted.
    logic [24:0] qa[$];
    logic [24:0] qb[$];
    int vprob_a, vprob_b, rprob, clrprob;

    // Reference model: who holds the strip (-1 = nobody), who held it last.
    int   m_holder;
    logic m_rr_last, m_last_owner, m_flag, m_fd_next;
    int   m_stall;
    bit   xa, xb;

    // DUT observations used by the frame-level checks.
    int          dut_grants[$];
    logic [25:0] got_px[$];
    logic        prev_busy;

    task automatic model_reset();
        m_holder = -1; m_rr_last = 1'b1; m_last_owner = 1'b0;
        m_flag = 1'b0; m_fd_next = 1'b0; m_stall = 0;
        xa = 0; xb = 0; prev_busy = 1'b0;
        dut_grants.delete(); got_px.delete();
    endtask

    task automatic push_frame(input int which, input int len);
        for (int i = 0; i < len; i++) begin
            if (which == 0) qa.push_back({(i == len - 1), 24'($urandom)});
            else            qb.push_back({(i == len - 1), 24'($urandom)});
        end
    endtask

    task automatic drive();
        if (xa) begin void'(qa.pop_front()); a_if.valid = 1'b0; end
        if (xb) begin void'(qb.pop_front()); b_if.valid = 1'b0; end
        if (!a_if.valid && qa.size() != 0 && $urandom_range(99) < vprob_a) a_if.valid = 1'b1;
        if (!b_if.valid && qb.size() != 0 && $urandom_range(99) < vprob_b) b_if.valid = 1'b1;
        if (a_if.valid) {a_if.latch, a_if.data} = qa[0];
        else begin a_if.latch = 1'($urandom_range(1)); a_if.data = 24'($urandom); end
        if (b_if.valid) {b_if.latch, b_if.data} = qb[0];
        else begin b_if.latch = 1'($urandom_range(1)); b_if.data = 24'($urandom); end
        s_if.ready  = ($urandom_range(99) < rprob);
        timeout_clr = ($urandom_range(99) < clrprob);
    endtask

    task automatic sample();
        logic hv, hl, sr, new_fd, to_evt;
        logic [23:0] hd;
        sr = s_if.ready;
        new_fd = 1'b0; to_evt = 1'b0;
        xa = 0; xb = 0;
        check_eq("frame_done", frame_done, m_fd_next);
        check_eq("timeout_flag", timeout_flag, m_flag);
        if (m_holder < 0) begin
            check_eq("idle_busy", busy, 0);
            check_eq("idle_a_ready", a_if.ready, 0);
            check_eq("idle_b_ready", b_if.ready, 0);
            check_eq("idle_s_valid", s_if.valid, 0);
            check_eq("idle_owner", owner, m_last_owner);
            if (a_if.valid && b_if.valid) m_holder = m_rr_last ? 0 : 1;
            else if (a_if.valid)          m_holder = 0;
            else if (b_if.valid)          m_holder = 1;
            if (m_holder >= 0) begin m_last_owner = m_holder[0]; m_stall = 0; end
        end else begin
            hv = (m_holder == 1) ? b_if.valid : a_if.valid;
            hl = (m_holder == 1) ? b_if.latch : a_if.latch;
            hd = (m_holder == 1) ? b_if.data  : a_if.data;
            check_eq("own_busy", busy, 1);
            check_eq("own_owner", owner, m_holder);
            check_eq("own_s_valid", s_if.valid, hv);
            check_eq("own_s_data", s_if.data, hd);
            if (hv) check_eq("own_s_latch", s_if.latch, hl);
            check_eq("own_a_ready", a_if.ready, (m_holder == 0) && sr);
            check_eq("own_b_ready", b_if.ready, (m_holder == 1) && sr);
            if (hv && sr) begin
                if (m_holder == 0) xa = 1; else xb = 1;
                m_stall = 0;
                if (hl) begin new_fd = 1'b1; m_rr_last = m_holder[0]; m_holder = -1; end
            end else begin
`ifdef WS2812B_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall >= TO_CYC) begin to_evt = 1'b1; m_rr_last = m_holder[0]; m_holder = -1; end
`endif
            end
        end
`ifdef WS2812B_ARB_TIMEOUT_EN
        if (to_evt) m_flag = 1'b1; else if (timeout_clr) m_flag = 1'b0;
`endif
        m_fd_next = new_fd;
        if (busy && !prev_busy) dut_grants.push_back(int'(owner));
        prev_busy = busy;
        if (s_if.valid && sr) got_px.push_back({owner, s_if.latch, s_if.data});
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        a_if.valid = 1'b0; b_if.valid = 1'b0; a_if.latch = 1'b0; b_if.latch = 1'b0;
        a_if.data = '0; b_if.data = '0; s_if.ready = 1'b0; timeout_clr = 1'b0;
        vprob_a = 100; vprob_b = 100; rprob = 100; clrprob = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_s_valid", s_if.valid, 0);
        check_eq("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while (!(qa.size() == 0 && qb.size() == 0 && m_holder < 0 && !a_if.valid &&
                 !b_if.valid && !m_fd_next) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check_eq("drain_budget", n, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_b, na, n;

        // Single frame from A, s_ready held high.
        do_reset();
        qa.push_back(25'h0_002000); qa.push_back(25'h0_200000); qa.push_back(25'h1_000020);
        run_drain(50);
        check_eq("t1_px_count", got_px.size(), 3);
        if (got_px.size() == 3) begin
            check_eq("t1_px0", got_px[0], 26'h0002000);
            check_eq("t1_px1", got_px[1], 26'h0200000);
            check_eq("t1_px2", got_px[2], 26'h1000020);
        end
        check_eq("t1_owner", owner, 0);

        // Tie in the first cycle after reset: A first, then B.
        do_reset();
        push_frame(0, 2); push_frame(1, 2);
        run_drain(50);
        check_eq("t2_grants", dut_grants.size(), 2);
        if (dut_grants.size() == 2) begin
            check_eq("t2_first", dut_grants[0], 0);
            check_eq("t2_second", dut_grants[1], 1);
        end

        // B requests mid-frame of a 35-pixel A frame with s_ready pulsing.
        do_reset();
        rprob = 50;
        push_frame(0, 35);
        repeat (5) step();
        push_frame(1, 4);
        run_drain(800);
        first_b = -1; na = 0;
        foreach (got_px[i]) begin
            if (got_px[i][25] == 1'b0) na++;
            else if (first_b < 0) first_b = i;
        end
        check_eq("t3_first_b_idx", first_b, 35);
        check_eq("t3_a_count", na, 35);

        // Fairness: both continuously valid, 2-pixel frames.
        do_reset();
        for (int f = 0; f < 4; f++) begin push_frame(0, 2); push_frame(1, 2); end
        run_drain(200);
        check_eq("t4_grants", dut_grants.size(), 8);
        if (dut_grants.size() == 8)
            foreach (dut_grants[i]) check_eq("t4_alternate", dut_grants[i], i % 2);

        // Owner stalls after one non-latch pixel while B is pending.
        do_reset();
        qa.push_back({1'b0, 24'($urandom)});
        push_frame(1, 2);
        for (int i = 0; i < 10 && !xa; i++) step();
        check_eq("t5_first_px", xa, 1);
`ifdef WS2812B_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) break;
            n++;
        end
        check_eq("t5_stall_cycles", n, TO_CYC);
        check_eq("t5_flag_set", timeout_flag, 1);
        check_eq("t5_no_frame_done", frame_done, 0);
        step();
        check_eq("t5_b_busy", busy, 1);
        check_eq("t5_b_owner", owner, 1);
        run_drain(100);
        clrprob = 100; step(); clrprob = 0; step();
        check_eq("t5_flag_clr", timeout_flag, 0);
        qa.push_back({1'b1, 24'($urandom)});
        run_drain(100);
`else
        repeat (40) step();
        check_eq("t5_hold_busy", busy, 1);
        check_eq("t5_hold_owner", owner, 0);
        check_eq("t5_hold_b_ready", b_if.ready, 0);
        check_eq("t5_no_flag", timeout_flag, 0);
        qa.push_back({1'b1, 24'($urandom)});
        run_drain(100);
        check_eq("t5_grants", dut_grants.size(), 2);
        if (dut_grants.size() == 2) check_eq("t5_then_b", dut_grants[1], 1);
`endif

        // Randomized traffic with random gaps, backpressure and flag clears.
        do_reset();
        rprob = 70; clrprob = 3;
        for (int c = 0; c < 3000; c++) begin
            if (qa.size() < 3) push_frame(0, $urandom_range(1, 6));
            if (qb.size() < 3) push_frame(1, $urandom_range(1, 6));
            if ((c % 200) == 0) begin
                vprob_a = $urandom_range(20, 100);
                vprob_b = $urandom_range(20, 100);
            end
            step();
        end
        vprob_a = 100; vprob_b = 100; rprob = 100;
        run_drain(2000);

        // Asynchronous reset between edges while A owns.
        do_reset();
        push_frame(0, 10);
        repeat (4) step();
        check_eq("t7_pre_busy", busy, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_eq("t7_a_ready", a_if.ready, 0);
        check_eq("t7_b_ready", b_if.ready, 0);
        check_eq("t7_s_valid", s_if.valid, 0);
        check_eq("t7_s_latch", s_if.latch, 0);
        check_eq("t7_s_data", s_if.data, 0);
        check_eq("t7_busy", busy, 0);
        check_eq("t7_owner", owner, 0);
        check_eq("t7_frame_done", frame_done, 0);
        check_eq("t7_timeout_flag", timeout_flag, 0);
        do_reset();
        push_frame(1, 2);
        run_drain(50);
        check_eq("t7_after_grant", dut_grants.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ws2812b_strip_arbiter.md
# ws2812b_strip_arbiter

Shares one ws2812b serializer between two pixel requesters, A (the CPU register path) and B (a secondary source such as an animation engine or a second peripheral). The arbiter sits between those sources and the ws2812b instance's data/valid/latch/ready port. It grants the strip for a whole frame, from the first pixel through the pixel carrying latch, so pixel streams are never interleaved. It alternates ownership round-robin and reports frame completion and status to the peripheral register layer.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 4096: idle cycles a granted owner may stall mid-frame before forced release. Legal range 2..65535.

Ports:
- clk  in  1  peripheral clock (64 MHz nominal)
- rst_n  in  1  reset; asynchronous, active-low
- a_data  in  24  requester A pixel, GRB order as the serializer expects
- a_valid  in  1  requester A pixel offered
- a_latch  in  1  requester A: this pixel ends the frame
- a_ready  out  1  requester A pixel accepted this cycle when a_valid also high
- b_data, b_valid, b_latch, b_ready: same as A, for requester B
- s_data  out  24  to serializer data_in
- s_valid  out  1  to serializer valid
- s_latch  out  1  to serializer latch
- s_ready  in  1  from serializer ready
- busy  out  1  a frame owner is currently granted
- owner  out  1  current or last owner (0 = A, 1 = B)
- frame_done  out  1  one-cycle pulse when a latch pixel transfers
- timeout_flag  out  1  sticky; set by forced release
- timeout_clr  in  1  clears timeout_flag

## Operation
- Transfer on a port occurs when valid && ready are both high in the same cycle.
- State machine: IDLE, OWN.
- IDLE:
  - All x_ready = 0; s_valid = 0.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one that is not rr_last.
  - On a grant, register owner, go to OWN, and clear the stall counter.
- OWN:
  - Combinational pass-through: s_data/s_valid/s_latch = owner's inputs.
  - owner_ready = s_ready; the non-owner's ready = 0.
  - On an owner transfer with latch = 1: pulse frame_done next cycle, set rr_last = owner, return to IDLE.
- Non-owner valid is ignored. It is held off, not dropped; the requester keeps valid asserted.
- busy = (state == OWN). owner resets to 0. rr_last resets to 1, so A wins the first tie.
- Stall counter is 16 bits:
  - Increments each OWN cycle without an owner transfer.
  - Clears on any transfer.
  - Saturates at TIMEOUT_CYCLES.
- Reset mid-frame: returns immediately to IDLE with all outputs at reset values. The serializer is reset by the same rst_n.
- timeout_clr and timeout set in the same cycle: set wins.

## Timing
- Reset values: a_ready = b_ready = 0, s_valid = 0, s_latch = 0, s_data = 0, busy = 0, owner = 0, frame_done = 0, timeout_flag = 0.
- Grant latency: a request arriving in IDLE at cycle n can transfer at cycle n+1 at the earliest.
- Passing through IDLE costs exactly one cycle. So after a latch transfer at cycle n, the next frame's first transfer is at n+2 at the earliest.
- Pass-through path is zero-latency combinational. Its only registered element is owner.
- frame_done is asserted in the cycle after the latch transfer, for one cycle.

## Configuration
- WS2812B_ARB_TIMEOUT_EN defined:
  - Stall counter present.
  - When it reaches TIMEOUT_CYCLES in OWN: force IDLE next cycle, set timeout_flag, set rr_last = owner, no frame_done.
  - The serializer receives no latch. The next frame's pixels continue the strip.
- Not defined:
  - No counter; timeout_flag is tied to 0 and timeout_clr is ignored.
  - The owner holds the grant indefinitely until its latch pixel.

## Structure
- Shared ws2812b package holds:
  - WS2812B_PIXEL_W = 24.
  - Owner encoding constants OWNER_A = 1'b0 and OWNER_B = 1'b1.
  - State enum: IDLE, OWN.
- Single flat module; no sub-module needed. The round-robin pick is a few gates and stays inline.
- Instantiated in the ledstrip peripheral between the register logic (A) and the ws2812b instance.

## Test plan
- Single frame: A sends 3 pixels (0x002000, 0x200000, 0x000020 with latch) with s_ready held high. Expect:
  - 3 s_valid transfers carrying the same data, in order.
  - busy high from grant to latch.
  - frame_done pulse one cycle after the third transfer; owner = 0.
- Tie at reset: A and B both valid in the first cycle after reset. Expect:
  - A granted first.
  - After A's latch, B granted after exactly one IDLE cycle.
  - b_ready stays 0 throughout A's frame.
- No interleave: B requests mid-frame of A (A sends 35 pixels with s_ready pulsing). Expect:
  - All 35 A pixels before any B pixel.
  - B data never appears on s_data while owner = 0.
- Fairness: both valid continuously, each sending 2-pixel frames. Expect grants alternating A, B, A, B across 8 frames.
- Timeout (macro on, TIMEOUT_CYCLES = 16): A sends 1 non-latch pixel, then drops valid. Expect:
  - Forced IDLE 16 cycles after that transfer; timeout_flag = 1; no frame_done.
  - Pending B granted next.
  - timeout_clr clears the flag.
- Async reset mid-frame: assert rst_n low between two clock edges while A owns. Expect all outputs at reset values immediately, before the next edge; busy = 0.
